// File: rtl/alu_regfile_wb.sv
// alu_regfile_wb
// Writeback end of the ALU interface. Holds the two-entry register array
// (regA = address 0, regB = address 1) and the PC. Accepts one instruction
// from the supplier, presents it to the combinational ALU for one cycle,
// then commits the ALU result/flags to the registers, PC and sticky status.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_instr   instruction from supplier; in_ready high in IDLE
//   alu_instr           instruction held for the ALU
//   regA, regB          register values to the ALU
//   alu_result/flags    ALU outputs, flags = {zero, negative, overflow}
//   pc                  program counter
//   mem_req/mem_addr    one-cycle request for lw/sw with its address
//   done                one-cycle retire pulse
//   ovf_sticky          an overflow trap occurred
//   err_sticky          bad destination or unrecognised instruction occurred
//   retire_cnt          retired instruction count, wraps
//
// state | meaning
// IDLE  | waiting for an instruction, in_ready high
// EXEC  | ALU evaluating alu_instr; commit on this edge
module alu_regfile_wb #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter logic [31:0] REG_A_INIT = 32'h0000_0000,
    parameter logic [31:0] REG_B_INIT = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic [31:0]      alu_instr,
    output logic [31:0]      regA,
    output logic [31:0]      regB,
    input  logic [31:0]      alu_result,
    input  logic [2:0]       alu_flags,
    output logic [31:0]      pc,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic             done,
    output logic             ovf_sticky,
    output logic             err_sticky,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic {IDLE, EXEC} state_t;
    state_t state;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  dest;
    logic        wr_ovf;
    logic        wr_plain;
    logic        is_beq;
    logic        is_bne;
    logic        is_mem;
    logic        unknown;
    logic        taken;
    logic        ovf_trap;
    logic        dest_bad;
    logic [31:0] br_off;
    logic        neg_flag_unused;

    // The negative flag has no effect on commit.
    assign neg_flag_unused = alu_flags[1];

    assign in_ready = (state == IDLE);

    always_comb begin
        op       = alu_instr[31:26];
        funct    = alu_instr[5:0];
        dest     = (op == 6'h00) ? alu_instr[15:11] : alu_instr[20:16];
        wr_ovf   = 1'b0;
        wr_plain = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_mem   = 1'b0;
        if (op == 6'h00) begin
            case (funct)
                6'h20, 6'h22: wr_ovf = 1'b1;
                6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: wr_plain = 1'b1;
                default: ;
            endcase
        end else begin
            case (op)
                6'h08: wr_ovf = 1'b1;
                6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: wr_plain = 1'b1;
                6'h04: is_beq = 1'b1;
                6'h05: is_bne = 1'b1;
                6'h23, 6'h2B: is_mem = 1'b1;
                default: ;
            endcase
        end
        unknown  = !(wr_ovf || wr_plain || is_beq || is_bne || is_mem);
        taken    = (is_beq && alu_flags[2]) || (is_bne && !alu_flags[2]);
        ovf_trap = wr_ovf && alu_flags[0];
        dest_bad = (wr_ovf || wr_plain) && (dest[4:1] != 4'd0);
        br_off   = {{14{alu_instr[15]}}, alu_instr[15:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            regA       <= REG_A_INIT;
            regB       <= REG_B_INIT;
            pc         <= PC_RESET;
            alu_instr  <= 32'd0;
            mem_addr   <= 32'd0;
            mem_req    <= 1'b0;
            done       <= 1'b0;
            ovf_sticky <= 1'b0;
            err_sticky <= 1'b0;
            retire_cnt <= '0;
        end else begin
            done    <= 1'b0;
            mem_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_instr <= in_instr;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    state      <= IDLE;
                    done       <= 1'b1;
                    retire_cnt <= retire_cnt + 1'b1;
                    pc         <= taken ? (pc + 32'd4 + br_off) : (pc + 32'd4);
                    if (is_mem) begin
                        mem_req  <= 1'b1;
                        mem_addr <= alu_result;
                    end
                    if (ovf_trap) ovf_sticky <= 1'b1;
                    if (unknown || dest_bad) err_sticky <= 1'b1;
                    // Trapped or misaddressed writes are dropped entirely.
                    if ((wr_ovf || wr_plain) && !ovf_trap && !dest_bad) begin
                        if (dest[0]) regB <= alu_result;
                        else         regA <= alu_result;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
